// File: rtl/dcache_arbiter.sv
// dcache_arbiter: two-requester front end for a single-ported data cache.
// One access is in flight at a time (IDLE -> BUSY -> DONE). The winner's
// address, data and write enable are captured at grant, so requester inputs
// may change freely once the access is underway.
module dcache_arbiter #(
  parameter bit FIXED_PRIO = 1'b0  // 0: round-robin on ties, 1: m0 always wins
) (
  input  logic        clk_i,
  input  logic        rst_i,      // asynchronous, active-low

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,

  output logic [31:0] c_adr_o,
  output logic [31:0] c_dat_o,
  output logic        c_we_o,
  input  logic [31:0] c_dat_i,
  input  logic        c_stall_i,

  output logic [1:0]  owner_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] adr_q;        // captured address, drives the cache port
  logic [31:0] dat_q;        // captured write data, drives the cache port
  logic        c_we_q;       // captured write enable, only high while BUSY
  logic [1:0]  owner_q;      // one-hot owner of the in-flight access
  logic        last_m1_q;    // 1 when m1 was granted most recently
  logic [31:0] m0_dat_q;
  logic [31:0] m1_dat_q;
  logic        m0_ack_q;
  logic        m1_ack_q;

  logic        any_req;
  logic        grant_m1;

  // Pick the winner among current requests; a tie goes to whoever was not
  // served last, unless m0 has fixed priority.
  always_comb begin
    any_req  = m0_req_i | m1_req_i;
    grant_m1 = 1'b0;
    if (m0_req_i && m1_req_i) begin
      grant_m1 = FIXED_PRIO ? 1'b0 : ~last_m1_q;
    end else begin
      grant_m1 = m1_req_i;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      c_we_q    <= 1'b0;
      owner_q   <= 2'b00;
      last_m1_q <= 1'b1;     // m0 wins the first tie after reset
      m0_dat_q  <= '0;
      m1_dat_q  <= '0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            adr_q     <= grant_m1 ? m1_adr_i : m0_adr_i;
            dat_q     <= grant_m1 ? m1_dat_i : m0_dat_i;
            c_we_q    <= grant_m1 ? m1_we_i  : m0_we_i;
            owner_q   <= grant_m1 ? 2'b10    : 2'b01;
            last_m1_q <= grant_m1;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          // A stalled cycle leaves everything as is; the access retries.
          if (!c_stall_i) begin
            c_we_q <= 1'b0;
            if (owner_q[0]) begin
              m0_ack_q <= 1'b1;
              if (!c_we_q) m0_dat_q <= c_dat_i;
            end
            if (owner_q[1]) begin
              m1_ack_q <= 1'b1;
              if (!c_we_q) m1_dat_q <= c_dat_i;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          owner_q  <= 2'b00;
          state_q  <= IDLE;
        end
        default: begin
          c_we_q   <= 1'b0;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          owner_q  <= 2'b00;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign c_adr_o  = adr_q;
  assign c_dat_o  = dat_q;
  assign c_we_o   = c_we_q;
  assign owner_o  = owner_q;
  assign m0_dat_o = m0_dat_q;
  assign m1_dat_o = m1_dat_q;
  assign m0_ack_o = m0_ack_q;
  assign m1_ack_o = m1_ack_q;

endmodule
